// File: rtl/ttihp_counter.sv
// 8-bit programmable up/down counter tile: prescaled count enable, wrap or
// saturate at the range ends, sticky wrap flag, and a count/status output mux.
module ttihp_counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   logic [WIDTH-1:0] count_q, count_d;
   logic [2:0]       pre_q, pre_d;
   logic             wrap_q, wrap_d;

   logic       cnt_en, up, load, clear, sat_mode, out_sel;
   logic [2:0] pre_last;
   logic       at_limit;
   logic       tick;

   assign cnt_en   = ui_in[0];
   assign up       = ui_in[1];
   assign load     = ui_in[2];
   assign clear    = ui_in[3];
   assign sat_mode = ui_in[6];
   assign out_sel  = ui_in[7];

   always_comb begin
      pre_last = 3'd0;
      case (ui_in[5:4])
         2'b00:   pre_last = 3'd0;
         2'b01:   pre_last = 3'd1;
         2'b10:   pre_last = 3'd3;
         default: pre_last = 3'd7;
      endcase
   end

   // Doubles as the terminal-count status bit and the overflow predicate.
   assign at_limit = up ? (count_q == '1) : (count_q == '0);

   always_comb begin
      count_d = count_q;
      pre_d   = pre_q;
      wrap_d  = wrap_q;
      tick    = 1'b0;
      if (ena) begin
         if (clear) begin
            count_d = '0;
            pre_d   = '0;
            wrap_d  = 1'b0;
         end else if (load) begin
            count_d = uio_in;
            pre_d   = '0;
         end else if (cnt_en) begin
            // ">=" so a smaller divide selected mid-period ticks on the next cycle
            if (pre_q >= pre_last) begin
               tick  = 1'b1;
               pre_d = '0;
            end else begin
               pre_d = pre_q + 3'd1;
            end
         end
      end
      if (tick) begin
         if (at_limit) wrap_d = 1'b1;
         if (!(at_limit && sat_mode))
            count_d = up ? count_q + 1'b1 : count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
         pre_q   <= '0;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         pre_q   <= pre_d;
         wrap_q  <= wrap_d;
      end
   end

   assign uo_out  = out_sel ? {1'b0, pre_q, cnt_en, up, wrap_q, at_limit} : count_q;
   assign uio_out = '0;
   assign uio_oe  = '0;

endmodule

// File: tb/tb_ttihp_counter.sv
// Bench for ttihp_counter: directed walk through the main features with
// literal expectations, then random traffic checked each cycle against a model.
module tb_ttihp_counter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   int m_count = 0;
   int m_pre   = 0;
   bit m_wrap  = 1'b0;

   ttihp_counter #(.WIDTH(8)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      int n;
      int nxt;
      if (!rst_n) begin
         m_count = 0;
         m_pre   = 0;
         m_wrap  = 1'b0;
      end else if (ena) begin
         if (ui_in[3]) begin
            m_count = 0;
            m_pre   = 0;
            m_wrap  = 1'b0;
         end else if (ui_in[2]) begin
            m_count = int'(uio_in);
            m_pre   = 0;
         end else if (ui_in[0]) begin
            n = 1 << ui_in[5:4];
            if (m_pre >= n - 1) begin
               m_pre = 0;
               nxt = m_count + (ui_in[1] ? 1 : -1);
               if (nxt > 255 || nxt < 0) begin
                  m_wrap = 1'b1;
                  if (!ui_in[6]) m_count = (nxt + 256) % 256;
               end else begin
                  m_count = nxt;
               end
            end else begin
               m_pre = m_pre + 1;
            end
         end
      end
   end

   function automatic logic [7:0] exp_uo();
      logic tc;
      tc = ui_in[1] ? (m_count == 255) : (m_count == 0);
      if (ui_in[7]) return {1'b0, 3'(m_pre), ui_in[0], ui_in[1], m_wrap, tc};
      return 8'(m_count);
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         checks++;
         if (uo_out !== exp_uo()) begin
            errors++;
            $display("FAIL model_uo t=%0t ui_in=%h got %h want %h", $time, ui_in, uo_out, exp_uo());
         end
         checks++;
         if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
            errors++;
            $display("FAIL uio_tie t=%0t got out=%h oe=%h want 00/00", $time, uio_out, uio_oe);
         end
      end
   end

   task automatic cyc(input int k);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Checks DUT output and the model against the same hand-derived value.
   task automatic lit(input string name, input logic [7:0] want);
      #1;
      checks++;
      if (uo_out !== want) begin
         errors++;
         $display("FAIL %s dut got %h want %h", name, uo_out, want);
      end
      checks++;
      if (exp_uo() !== want) begin
         errors++;
         $display("FAIL %s model got %h want %h", name, exp_uo(), want);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit expired");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
      cyc(2);
      chk_en = 1'b1;
      rst_n = 1'b1;
      lit("reset", 8'h00);
      checks++;
      if (uio_oe !== 8'h00) begin
         errors++;
         $display("FAIL reset_oe got %h want 00", uio_oe);
      end
      cyc(10);
      lit("idle", 8'h00);

      ui_in = 8'h03; cyc(5); lit("up5", 8'h05);
      ui_in = 8'h01; cyc(2); lit("down2", 8'h03);

      uio_in = 8'hFE; ui_in = 8'h04; cyc(1); lit("load_fe", 8'hFE);
      ui_in = 8'h03;
      cyc(1); lit("wrap_ff", 8'hFF);
      cyc(1); lit("wrap_00", 8'h00);
      cyc(1); lit("wrap_01", 8'h01);
      ui_in = 8'h83; lit("status_wrap", 8'h0E);
      ui_in = 8'h08; cyc(1); lit("clear", 8'h00);
      ui_in = 8'h80; lit("status_clr", 8'h01);

      uio_in = 8'h01; ui_in = 8'h04; cyc(1); lit("load_01", 8'h01);
      ui_in = 8'h41;
      cyc(1); lit("sat_1", 8'h00);
      cyc(1); lit("sat_2", 8'h00);
      cyc(1); lit("sat_3", 8'h00);
      cyc(1); lit("sat_4", 8'h00);
      ui_in = 8'hC1; lit("status_sat", 8'h0B);

      ui_in = 8'h08; cyc(1);
      ui_in = 8'h33;
      for (int k = 1; k <= 24; k++) begin
         cyc(1);
         lit($sformatf("presc_%0d", k), 8'(k / 8));
      end
      cyc(3);
      ui_in = 8'h32; cyc(5); lit("presc_hold", 8'h03);
      ui_in = 8'hB2; lit("status_hold", 8'h34);

      uio_in = 8'h55; ui_in = 8'h0C; cyc(1); lit("clr_over_load", 8'h00);
      ui_in = 8'h03; cyc(2); lit("pre_ena", 8'h02);
      ena = 1'b0; cyc(5); lit("ena_hold", 8'h02);
      rst_n = 1'b0; cyc(1); lit("rst_no_ena", 8'h00);
      rst_n = 1'b1; ena = 1'b1;

      for (int i = 0; i < 3000; i++) begin
         ui_in     = 8'($urandom);
         ui_in[2]  = ($urandom_range(15) == 0);
         ui_in[3]  = ($urandom_range(31) == 0);
         uio_in    = 8'($urandom);
         ena       = ($urandom_range(9) != 0);
         rst_n     = ($urandom_range(199) != 0);
         cyc(1);
      end
      rst_n = 1'b1;
      cyc(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
